data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the CPU's data-memory port. It serves word load/store requests from the MEM stage over a valid/ready handshake with configurable access latency.
- Returns read data with a one-cycle response pulse and flags misaligned or out-of-range accesses.
- Owns a word-addressed data array that is zeroed on reset. The CPU holds its MEM stage stalled from request until it sees the response.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words in the array; word index = REQ_ADDR[31:2]
- LATENCY, 2, cycles from the accept edge to the RESP_VALID cycle; legal range 1..15

Ports:
- CLOCK  input  1  single clock, rising edge
- RESET  input  1  synchronous, active-high reset
- REQ_VALID  input  1  request present; CPU holds all REQ_* stable until RESP_VALID
- REQ_READY  output  1  responder can accept a request this cycle
- REQ_WE  input  1  1 = store word, 0 = load word
- REQ_ADDR  input  32  byte address
- REQ_WDATA  input  32  store data
- RESP_VALID  output  1  one-cycle pulse: access complete
- RESP_RDATA  output  32  load data; valid only while RESP_VALID=1
- RESP_ERR  output  1  access rejected; valid only while RESP_VALID=1
- BUSY  output  1  request accepted and not yet responded; for CPU stall logic

Behaviour:
- Reset (RESET=1 at a rising edge):
  - state goes to IDLE and the latency counter clears
  - REQ_READY=1 from the next cycle; RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0, BUSY=0
  - every array word is cleared to 0
  - RESET overrides everything in the same cycle, including a request being accepted
- FSM states: IDLE, WAIT, RESP.
  - IDLE: REQ_READY=1, BUSY=0. On REQ_VALID=1 the request is accepted at that edge: REQ_WE, the word index, REQ_WDATA and the error status are latched.
    - LATENCY=1: next state RESP.
    - otherwise: next state WAIT, counter loaded with LATENCY-1.
  - WAIT: REQ_READY=0, BUSY=1. Counter decrements each cycle. When the counter is 1, next state is RESP.
  - RESP: REQ_READY=0, BUSY=1, RESP_VALID=1 for exactly one cycle. Next state is always IDLE.
    - A new request can be accepted no earlier than the cycle after RESP.
    - The minimum request-to-request spacing is LATENCY+1 cycles.
- Latency: a request accepted at edge N gives RESP_VALID=1 during the cycle following edge N+LATENCY.
- Error condition, evaluated on the latched request: REQ_ADDR[1:0]!=0, or word index >= DEPTH_WORDS.
  - On error: no array write, RESP_RDATA=0, RESP_ERR=1.
- Loads:
  - the array is read at the edge that enters RESP
  - RESP_RDATA is registered and equals the array content at that moment
- Stores:
  - the array is written at the edge that enters RESP; RESP_RDATA=0 for stores
  - a load that follows a store to the same word returns the new data, because the accesses are strictly serialised
- RESP_RDATA and RESP_ERR return to 0 in every cycle where RESP_VALID=0.
- Request inputs are ignored while not IDLE. Changes to REQ_* after acceptance have no effect.
- Reset in WAIT or RESP:
  - the transaction is aborted, any pending store is dropped, and no RESP_VALID is produced
  - the array is zeroed regardless
- REQ_VALID=0 in IDLE: stays in IDLE, all outputs at their idle values.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, then 0 -> REQ_READY=1, BUSY=0, RESP_VALID=0; a load from address 0x00000040 returns RESP_RDATA=0, RESP_ERR=0.
- Store/load, LATENCY=2: store 0xDEADBEEF to 0x00000010 accepted at edge N -> RESP_VALID=1 only in the cycle after edge N+2; BUSY=1 for 3 cycles. Then load 0x00000010 -> RESP_RDATA=0xDEADBEEF.
- LATENCY=1 back-to-back with REQ_VALID held high:
  - store 0x12345678 @0x4, then load @0x4
  - accepts occur every 2 cycles; the load responds 0x12345678; exactly one RESP_VALID per request
- Error cases, each with RESP_ERR=1 and RESP_RDATA=0:
  - store to 0x00000006 (misaligned); a following load @0x4 still returns its previous value
  - load from 0x00000800 with DEPTH_WORDS=512 (out of range)
- Reset mid-operation: LATENCY=4, store 0xCAFEF00D @0x20; RESET=1 during WAIT -> no RESP_VALID; afterwards a load @0x20 returns 0.
- Input hold-off: change REQ_ADDR and REQ_WDATA while in WAIT -> response and array reflect only the values latched at acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: serialised word load/store
// with configurable latency, error flagging and a reset-cleared array.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RESP_VALID,
    output logic [31:0] RESP_RDATA,
    output logic        RESP_ERR,
    output logic        BUSY
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we_q;
    logic          err_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          addr_err;

    assign addr_err = (REQ_ADDR[1:0] != 2'b00) ||
                      ({2'b00, REQ_ADDR[31:2]} >= 32'(DEPTH_WORDS));

    assign REQ_READY = (state == IDLE);
    assign BUSY      = (state != IDLE) || RESP_VALID;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            RESP_VALID <= 1'b0;
            RESP_RDATA <= '0;
            RESP_ERR   <= 1'b0;
            mem        <= '{default: '0};
        end else begin
            RESP_VALID <= 1'b0;
            RESP_RDATA <= '0;
            RESP_ERR   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        we_q    <= REQ_WE;
                        err_q   <= addr_err;
                        idx_q   <= REQ_ADDR[AW+1:2];
                        wdata_q <= REQ_WDATA;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    // access commits as the pulse is registered, so a reset
                    // in WAIT or RESP drops it cleanly
                    state      <= IDLE;
                    RESP_VALID <= 1'b1;
                    RESP_ERR   <= err_q;
                    if (!err_q) begin
                        if (we_q) mem[idx_q] <= wdata_q;
                        else      RESP_RDATA <= mem[idx_q];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with
// LATENCY 2, 1 and 4 share a clock and are exercised independently.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic        busy       [3];

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) u_l2 (
        .CLOCK(clk), .RESET(rst[0]), .REQ_VALID(req_valid[0]),
        .REQ_READY(req_ready[0]), .REQ_WE(req_we[0]), .REQ_ADDR(req_addr[0]),
        .REQ_WDATA(req_wdata[0]), .RESP_VALID(resp_valid[0]),
        .RESP_RDATA(resp_rdata[0]), .RESP_ERR(resp_err[0]), .BUSY(busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(1)) u_l1 (
        .CLOCK(clk), .RESET(rst[1]), .REQ_VALID(req_valid[1]),
        .REQ_READY(req_ready[1]), .REQ_WE(req_we[1]), .REQ_ADDR(req_addr[1]),
        .REQ_WDATA(req_wdata[1]), .RESP_VALID(resp_valid[1]),
        .RESP_RDATA(resp_rdata[1]), .RESP_ERR(resp_err[1]), .BUSY(busy[1])
    );

    data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(4)) u_l4 (
        .CLOCK(clk), .RESET(rst[2]), .REQ_VALID(req_valid[2]),
        .REQ_READY(req_ready[2]), .REQ_WE(req_we[2]), .REQ_ADDR(req_addr[2]),
        .REQ_WDATA(req_wdata[2]), .RESP_VALID(resp_valid[2]),
        .RESP_RDATA(resp_rdata[2]), .RESP_ERR(resp_err[2]), .BUSY(busy[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on instance k; observes 20 cycles after the accept edge.
    // lat is the cycle index (0 = cycle after accept edge) of the pulse.
    task automatic xfer(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit mangle,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nbusy, output int nresp,
                        output int nstray);
        int t;
        t = 0;
        rdata = '0; err = 1'b0; lat = -1;
        nbusy = 0; nresp = 0; nstray = 0;
        req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        while (!req_ready[k] && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL xfer_ready_timeout dut%0d: ready=%b required 1",
                     k, req_ready[k]);
        end
        tick();
        req_valid[k] = mangle;
        if (mangle) begin
            req_addr[k]  = addr ^ 32'h4;
            req_wdata[k] = ~wdata;
        end
        for (int c = 0; c < 20; c++) begin
            if (busy[k]) nbusy++;
            if (resp_valid[k]) begin
                nresp++;
                if (lat < 0) begin
                    lat   = c;
                    rdata = resp_rdata[k];
                    err   = resp_err[k];
                end
            end else if (resp_rdata[k] != 32'h0 || resp_err[k]) begin
                nstray++;
            end
            if (c == 1) req_valid[k] = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat, nb, nr, ns;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d: got %b required 1",
                         k, req_ready[k]);
            end
            checks++;
            if (busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy dut%0d: got %b required 0", k, busy[k]);
            end
            checks++;
            if (resp_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_resp_valid dut%0d: got %b required 0",
                         k, resp_valid[k]);
            end
        end
        xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || nr != 1) begin
            errors++;
            $display("FAIL reset_load40: rdata=%h err=%b nresp=%0d required 0/0/1",
                     rd, er, nr);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, nb, nr, ns;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (lat != 2 || nb != 3 || nr != 1) begin
            errors++;
            $display("FAIL store10_timing: lat=%0d busy=%0d nresp=%0d required 2/3/1",
                     lat, nb, nr);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || ns != 0) begin
            errors++;
            $display("FAIL store10_resp: rdata=%h err=%b stray=%0d required 0/0/0",
                     rd, er, ns);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || ns != 0) begin
            errors++;
            $display("FAIL load10: rdata=%h err=%b stray=%0d required deadbeef/0/0",
                     rd, er, ns);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic er; int lat, nb, nr, ns;
        xfer(1, 1'b0, 32'h8, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (lat != 1 || nb != 2 || nr != 1) begin
            errors++;
            $display("FAIL lat1_timing: lat=%0d busy=%0d nresp=%0d required 1/2/1",
                     lat, nb, nr);
        end
        xfer(2, 1'b0, 32'h8, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (lat != 4 || nb != 5 || nr != 1) begin
            errors++;
            $display("FAIL lat4_timing: lat=%0d busy=%0d nresp=%0d required 4/5/1",
                     lat, nb, nr);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int nresp;
        logic [31:0] load_rd;
        bit sw, drop;
        nresp = 0; load_rd = '0; sw = 0; drop = 0;
        req_we[1] = 1'b1; req_addr[1] = 32'h4; req_wdata[1] = 32'h12345678;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (req_valid[1] && req_ready[1]) begin
                acc.push_back(c);
                if (acc.size() == 1) sw = 1; else drop = 1;
            end
            if (resp_valid[1]) begin
                nresp++;
                if (nresp == 2) load_rd = resp_rdata[1];
            end
            tick();
            if (sw) begin
                req_we[1] = 1'b0; req_wdata[1] = 32'h0; sw = 0;
            end
            if (drop) begin
                req_valid[1] = 1'b0; drop = 0;
            end
        end
        req_valid[1] = 1'b0;
        checks++;
        if (acc.size() != 2) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 2", acc.size());
        end else begin
            checks++;
            if (acc[1] - acc[0] != 2) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d required 2", acc[1] - acc[0]);
            end
        end
        checks++;
        if (nresp != 2 || load_rd !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_resp: nresp=%0d rdata=%h required 2/12345678",
                     nresp, load_rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, nb, nr, ns;
        xfer(0, 1'b1, 32'h4, 32'h55AA55AA, 1'b0, rd, er, lat, nb, nr, ns);
        xfer(0, 1'b1, 32'h6, 32'h99999999, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 2 || ns != 0) begin
            errors++;
            $display("FAIL misaligned_store: err=%b rdata=%h lat=%0d stray=%0d required 1/0/2/0",
                     er, rd, lat, ns);
        end
        xfer(0, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'h55AA55AA || er !== 1'b0) begin
            errors++;
            $display("FAIL load4_after_err: rdata=%h err=%b required 55aa55aa/0",
                     rd, er);
        end
        xfer(0, 1'b1, 32'h7FC, 32'h0BADF00D, 1'b0, rd, er, lat, nb, nr, ns);
        xfer(0, 1'b0, 32'h7FC, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL last_word: rdata=%h err=%b required 0badf00d/0", rd, er);
        end
        xfer(0, 1'b0, 32'h800, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || nr != 1) begin
            errors++;
            $display("FAIL out_of_range: err=%b rdata=%h nresp=%0d required 1/0/1",
                     er, rd, nr);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, nb, nr, ns;
        int t, n;
        xfer(2, 1'b1, 32'h20, 32'h11111111, 1'b0, rd, er, lat, nb, nr, ns);
        req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'hCAFEF00D;
        req_valid[2] = 1'b1;
        t = 0;
        while (!req_ready[2] && t < 50) begin
            tick();
            t++;
        end
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        checks++;
        if (req_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: ready=%b busy=%b required 1/0",
                     req_ready[2], busy[2]);
        end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid[2]) n++;
            tick();
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mid_reset_noresp: got %0d pulses required 0", n);
        end
        xfer(2, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || nr != 1) begin
            errors++;
            $display("FAIL mid_reset_load20: rdata=%h err=%b nresp=%0d required 0/0/1",
                     rd, er, nr);
        end
    endtask

    task automatic test_hold_off();
        logic [31:0] rd; logic er; int lat, nb, nr, ns;
        xfer(0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b1, rd, er, lat, nb, nr, ns);
        checks++;
        if (nr != 1 || lat != 2 || er !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_store: nresp=%0d lat=%0d err=%b required 1/2/0",
                     nr, lat, er);
        end
        xfer(0, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL holdoff_load30: got %h required a5a5a5a5", rd);
        end
        xfer(0, 1'b0, 32'h34, 32'h0, 1'b0, rd, er, lat, nb, nr, ns);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL holdoff_load34: got %h required 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_latency();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_hold_off();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
